// File: rtl/pcileech_sysctl_pkg.sv
// Shared types and constants for the AC701 system-control stage.
package pcileech_sysctl_pkg;

  // Reset sequencer states: hold the system in reset, or let it run.
  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } sysctl_state_t;

  // Bit positions inside gpio_led.
  localparam int LED_HB   = 0;
  localparam int LED_COM  = 1;
  localparam int LED_PCIE = 2;

endpackage

// File: rtl/pcileech_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one raw button.
module pcileech_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  output logic dout
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din_async;
      sync2 <= sync1;
    end
  end

  // Follow the synchronized level only once it has differed long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (sync2 == dout) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt  <= '0;
      dout <= ~dout;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pcileech_sysctl_ac701.sv
// AC701 system control: debounced buttons, minimum-width system reset,
// FT601 reset, free-running tick counter and heartbeat/activity LEDs.
// Optional LED activity stretching is enabled with PCILEECH_SYSCTL_LED_STRETCH_EN.
module pcileech_sysctl_ac701
  import pcileech_sysctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RST_HOLD_CYCLES = 64,
  parameter int STRETCH_CYCLES  = 5000000,
  parameter int HEARTBEAT_BIT   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gpio_sw_north,
  input  logic        gpio_sw_south,
  input  logic        pcie_perst_n,
  input  logic        act_com,
  input  logic        act_pcie,
  output logic        rst_sys,
  output logic        ft601_rst_n,
  output logic        sw_south_db,
  output logic        perst_n_sync,
  output logic [63:0] tickcount64,
  output logic [2:0]  gpio_led
);

  localparam int HW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_TERM = HW'(RST_HOLD_CYCLES - 1);

  logic          north_db;
  logic          north_db_q;
  logic          perst_s1;
  sysctl_state_t state_q;
  sysctl_state_t state_d;
  logic [HW-1:0] hold_cnt_q;
  logic [HW-1:0] hold_cnt_d;
  logic          rst_sys_d;
  logic [63:0]   tick_next;
  logic          led_hb;
  logic          led_com;
  logic          led_pcie;

  pcileech_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_north (
    .clk       (clk),
    .rst       (rst),
    .din_async (gpio_sw_north),
    .dout      (north_db)
  );

  pcileech_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_south (
    .clk       (clk),
    .rst       (rst),
    .din_async (gpio_sw_south),
    .dout      (sw_south_db)
  );

  // PERST# is only forwarded, so it needs nothing beyond synchronization.
  always_ff @(posedge clk) begin
    if (rst) begin
      perst_s1     <= 1'b0;
      perst_n_sync <= 1'b0;
    end else begin
      perst_s1     <= pcie_perst_n;
      perst_n_sync <= perst_s1;
    end
  end

  // Reset sequencer: count release time in HOLD, re-enter HOLD on a button press.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (north_db) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_TERM) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (north_db && !north_db_q) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase
    rst_sys_d = (state_d == ST_HOLD);
  end

  // Sequencer state plus both reset outputs, registered from the same next state
  // so the FT601 reset can never skew against the system reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      north_db_q  <= 1'b0;
      rst_sys     <= 1'b1;
      ft601_rst_n <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      north_db_q  <= north_db;
      rst_sys     <= rst_sys_d;
      ft601_rst_n <= ~rst_sys_d;
    end
  end

  assign tick_next = tickcount64 + 64'd1;

  // Free-running tick counter and the heartbeat LED derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tickcount64 <= '0;
      led_hb      <= 1'b0;
    end else begin
      tickcount64 <= tick_next;
      led_hb      <= sw_south_db ^ north_db ^ tick_next[HEARTBEAT_BIT];
    end
  end

`ifdef PCILEECH_SYSCTL_LED_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  logic          com_q;
  logic          pcie_q;
  logic [SW-1:0] com_cnt;
  logic [SW-1:0] pcie_cnt;
  logic [SW-1:0] com_cnt_d;
  logic [SW-1:0] pcie_cnt_d;

  // Reload on each activity rising edge, otherwise run down to zero and stay.
  always_comb begin
    com_cnt_d  = com_cnt;
    pcie_cnt_d = pcie_cnt;
    if (act_com && !com_q) begin
      com_cnt_d = SW'(STRETCH_CYCLES);
    end else if (com_cnt != '0) begin
      com_cnt_d = com_cnt - SW'(1);
    end
    if (act_pcie && !pcie_q) begin
      pcie_cnt_d = SW'(STRETCH_CYCLES);
    end else if (pcie_cnt != '0) begin
      pcie_cnt_d = pcie_cnt - SW'(1);
    end
  end

  // Stretched activity LEDs, dark while the system is held in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      com_q    <= 1'b0;
      pcie_q   <= 1'b0;
      com_cnt  <= '0;
      pcie_cnt <= '0;
      led_com  <= 1'b0;
      led_pcie <= 1'b0;
    end else begin
      com_q    <= act_com;
      pcie_q   <= act_pcie;
      com_cnt  <= com_cnt_d;
      pcie_cnt <= pcie_cnt_d;
      led_com  <= !rst_sys_d && (com_cnt_d != '0);
      led_pcie <= !rst_sys_d && (pcie_cnt_d != '0);
    end
  end
`else
  // Activity LEDs as plain registered copies, dark while the system is held in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_com  <= 1'b0;
      led_pcie <= 1'b0;
    end else begin
      led_com  <= !rst_sys_d && act_com;
      led_pcie <= !rst_sys_d && act_pcie;
    end
  end
`endif

  assign gpio_led[LED_HB]   = led_hb;
  assign gpio_led[LED_COM]  = led_com;
  assign gpio_led[LED_PCIE] = led_pcie;

endmodule
